// File: rtl/fml16_pkg.sv
// Shared types and constants for the FML16 -> WB32 responder.
package fml16_pkg;

  // Responder FSM encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_WB_WR = 3'd2,
    S_WB_RD = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  // fml_adr_i[1] selects which half of the 32-bit word is addressed.
  localparam logic HALF_UPPER = 1'b0;
  localparam logic HALF_LOWER = 1'b1;

  // Classic Wishbone cycle type identifier.
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;

  // Extract the addressed 16-bit half from a 32-bit word.
  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic half);
    return (half == HALF_LOWER) ? word[15:0] : word[31:16];
  endfunction

endpackage

// File: rtl/fml16_wb32_responder_if.sv
// Bus bundle for the responder: FML16 slave side plus WB32 master side.
//
// Handshakes:
//   FML: the master raises fml_stb_i with adr/we/sel/di and holds them until
//        fml_ack_o pulses for exactly one cycle; read data is valid in that
//        cycle. The responder only samples a request while fml_ack_o is low.
//   WB : classic cycles. wb_cyc_o = wb_stb_o = 1 with adr/dat/sel/we stable
//        until the slave asserts wb_ack_i; cyc/stb drop in the following cycle.
interface fml16_wb32_responder_if #(parameter int ADR_W = 26);
  logic [ADR_W-1:0] fml_adr_i;
  logic             fml_stb_i;
  logic             fml_we_i;
  logic [1:0]       fml_sel_i;
  logic [15:0]      fml_di_i;
  logic [15:0]      fml_do_o;
  logic             fml_ack_o;

  logic [31:0]      wb_adr_o;
  logic [31:0]      wb_dat_o;
  logic [31:0]      wb_dat_i;
  logic [3:0]       wb_sel_o;
  logic [2:0]       wb_cti_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic             wb_ack_i;

  // Responder view.
  modport slave (
    input  fml_adr_i, fml_stb_i, fml_we_i, fml_sel_i, fml_di_i,
    output fml_do_o, fml_ack_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_ack_i
  );

  // Environment view (FML master and WB slave).
  modport master (
    output fml_adr_i, fml_stb_i, fml_we_i, fml_sel_i, fml_di_i,
    input  fml_do_o, fml_ack_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/fml16_wb32_wbm.sv
// Single classic-cycle Wishbone master. A start pulse while idle registers the
// command and raises cyc/stb; the cycle ends on wb_ack_i. done and rdata are
// combinational views of the acknowledging cycle so the caller can react on
// the same edge the ack is sampled.
module fml16_wb32_wbm
  import fml16_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  input  logic [3:0]  sel,
  output logic        done,
  output logic [31:0] rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  assign done   = wb_cyc & wb_ack_i;
  assign rdata  = wb_dat_i;
  assign wb_cti = WB_CTI_CLASSIC;

  // Hold the command stable from start until the slave acknowledges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wb_cyc <= 1'b0;
      wb_stb <= 1'b0;
      wb_we  <= 1'b0;
      wb_adr <= '0;
      wb_dat <= '0;
      wb_sel <= '0;
    end else if (wb_cyc) begin
      if (wb_ack_i) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
        wb_we  <= 1'b0;
      end
    end else if (start) begin
      wb_cyc <= 1'b1;
      wb_stb <= 1'b1;
      wb_we  <= we;
      wb_adr <= adr;
      wb_dat <= dat;
      wb_sel <= sel;
    end
  end

endmodule

// File: rtl/fml16_wb32_responder.sv
// FML16 slave that packs half-word accesses into 32-bit Wishbone cycles.
// An upper-half write is parked in a pending buffer and merged with the
// following lower-half write; a one-word read cache serves the second half of
// a read pair without another bus cycle.
module fml16_wb32_responder
  import fml16_pkg::*;
#(
  parameter int ADR_W = 26
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  fml16_wb32_responder_if.slave  bus,
  output state_t                 dbg_state
);

  localparam int WA_W = ADR_W - 2;
  typedef logic [WA_W-1:0] wadr_t;

  state_t      state;
  logic        fml_ack;
  logic [15:0] fml_do;

  // Pending upper-half write.
  logic        pend_v;
  wadr_t       pend_adr;
  logic [15:0] hi_dat;
  logic [1:0]  hi_sel;

  // One-word read cache.
  logic        cache_v;
  wadr_t       cache_adr;
  logic [31:0] cache;

  // Request captured at dispatch so the master may drop stb mid-operation.
  wadr_t       req_adr;
  logic        req_half;
  logic        req_we;
  logic [1:0]  req_sel;
  logic [15:0] req_di;
  logic        need_launch;

  wadr_t       in_adr;
  logic        in_half;
  logic        take;
  logic        pend_match;
  logic        cache_match;
  logic        req_cache_match;
  logic        unused_adr_bit;

  logic        launch;
  logic        l_we;
  logic [31:0] l_adr;
  logic [31:0] l_dat;
  logic [3:0]  l_sel;
  logic        go_hi;
  logic        go_flush;
  logic        go_wr;
  logic        go_hit;
  logic        wb_done;
  logic [31:0] wb_rdata;

  assign in_adr          = bus.fml_adr_i[ADR_W-1:2];
  assign in_half         = bus.fml_adr_i[1];
  assign unused_adr_bit  = bus.fml_adr_i[0];
  assign take            = (state == S_IDLE) && bus.fml_stb_i && !fml_ack;
  assign pend_match      = pend_v && (in_adr == pend_adr);
  assign cache_match     = cache_v && (in_adr == cache_adr);
  assign req_cache_match = cache_v && (req_adr == cache_adr);

  // Dispatch decision and the Wishbone command to launch this cycle, if any.
  always_comb begin
    launch   = 1'b0;
    l_we     = 1'b0;
    l_adr    = '0;
    l_dat    = '0;
    l_sel    = '0;
    go_hi    = 1'b0;
    go_flush = 1'b0;
    go_wr    = 1'b0;
    go_hit   = 1'b0;
    if (take) begin
      if (bus.fml_we_i && (in_half == HALF_UPPER)) begin
        go_hi = 1'b1;
      end else if (pend_v && !(bus.fml_we_i && pend_match)) begin
        go_flush = 1'b1;
        launch   = 1'b1;
        l_we     = 1'b1;
        l_adr    = 32'({pend_adr, 2'b00});
        l_dat    = {hi_dat, 16'h0000};
        l_sel    = {hi_sel, 2'b00};
      end else if (bus.fml_we_i) begin
        go_wr  = 1'b1;
        launch = 1'b1;
        l_we   = 1'b1;
        l_adr  = 32'({in_adr, 2'b00});
        l_dat  = pend_v ? {hi_dat, bus.fml_di_i} : {16'h0000, bus.fml_di_i};
        l_sel  = pend_v ? {hi_sel, bus.fml_sel_i} : {2'b00, bus.fml_sel_i};
      end else if (cache_match) begin
        go_hit = 1'b1;
      end else begin
        launch = 1'b1;
        l_adr  = 32'({in_adr, 2'b00});
        l_sel  = 4'hF;
      end
    end else if (need_launch) begin
      // Deferred command after a flush; the pending buffer is empty by now.
      launch = 1'b1;
      l_adr  = 32'({req_adr, 2'b00});
      if (state == S_WB_WR) begin
        l_we  = 1'b1;
        l_dat = {16'h0000, req_di};
        l_sel = {2'b00, req_sel};
      end else begin
        l_sel = 4'hF;
      end
    end
  end

  // Responder FSM with pending-write buffer and read cache.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      fml_ack     <= 1'b0;
      fml_do      <= '0;
      pend_v      <= 1'b0;
      pend_adr    <= '0;
      hi_dat      <= '0;
      hi_sel      <= '0;
      cache_v     <= 1'b0;
      cache_adr   <= '0;
      cache       <= '0;
      req_adr     <= '0;
      req_half    <= 1'b0;
      req_we      <= 1'b0;
      req_sel     <= '0;
      req_di      <= '0;
      need_launch <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            req_adr  <= in_adr;
            req_half <= in_half;
            req_we   <= bus.fml_we_i;
            req_sel  <= bus.fml_sel_i;
            req_di   <= bus.fml_di_i;
            // Writes never update the cache, so any write to the cached word kills it.
            if (bus.fml_we_i && cache_match) cache_v <= 1'b0;
            if (go_hi) begin
              hi_dat   <= bus.fml_di_i;
              hi_sel   <= bus.fml_sel_i;
              pend_adr <= in_adr;
              pend_v   <= 1'b1;
              fml_ack  <= 1'b1;
              state    <= S_ACK;
            end else if (go_flush) begin
              state <= S_FLUSH;
            end else if (go_wr) begin
              pend_v <= 1'b0;
              state  <= S_WB_WR;
            end else if (go_hit) begin
              fml_do  <= pick_half(cache, in_half);
              fml_ack <= 1'b1;
              state   <= S_ACK;
            end else begin
              state <= S_WB_RD;
            end
          end
        end
        S_FLUSH: begin
          if (wb_done) begin
            pend_v <= 1'b0;
            if (req_we) begin
              need_launch <= 1'b1;
              state       <= S_WB_WR;
            end else if (req_cache_match) begin
              fml_do  <= pick_half(cache, req_half);
              fml_ack <= 1'b1;
              state   <= S_ACK;
            end else begin
              need_launch <= 1'b1;
              state       <= S_WB_RD;
            end
          end
        end
        S_WB_WR: begin
          need_launch <= 1'b0;
          if (wb_done) begin
            fml_ack <= 1'b1;
            state   <= S_ACK;
          end
        end
        S_WB_RD: begin
          need_launch <= 1'b0;
          if (wb_done) begin
            cache     <= wb_rdata;
            cache_adr <= req_adr;
            cache_v   <= 1'b1;
            fml_do    <= pick_half(wb_rdata, req_half);
            fml_ack   <= 1'b1;
            state     <= S_ACK;
          end
        end
        S_ACK: begin
          fml_ack <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          fml_ack <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  fml16_wb32_wbm u_wbm (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (launch),
    .we        (l_we),
    .adr       (l_adr),
    .dat       (l_dat),
    .sel       (l_sel),
    .done      (wb_done),
    .rdata     (wb_rdata),
    .wb_cyc    (bus.wb_cyc_o),
    .wb_stb    (bus.wb_stb_o),
    .wb_we     (bus.wb_we_o),
    .wb_adr    (bus.wb_adr_o),
    .wb_dat    (bus.wb_dat_o),
    .wb_sel    (bus.wb_sel_o),
    .wb_cti    (bus.wb_cti_o),
    .wb_dat_i  (bus.wb_dat_i),
    .wb_ack_i  (bus.wb_ack_i)
  );

  assign bus.fml_ack_o = fml_ack;
  assign bus.fml_do_o  = fml_do;
  assign dbg_state     = state;

endmodule

// File: doc/fml16_wb32_responder.md
Name: fml16_wb32_responder

Overview:
- FML slave for the 16-bit DDR-side bus that packs half-word accesses into 32-bit Wishbone master cycles toward a 32-bit memory/peripheral.
- Responder counterpart of the existing WB32-to-FML16 splitter: that splitter issues the upper half (adr[1]=0) first, then the lower half (adr[1]=1). This block reassembles the pair.
- Buffers the upper write half and holds a one-word read cache, so a standard upper/lower pair costs one Wishbone cycle.

Parameters:
- ADR_W, 26, FML address width; matches `SDRAM_DEPTH.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- fml_adr_i  in  ADR_W  half-word byte address; bit1 selects half (0=upper, wb bytes 3:2; 1=lower, wb bytes 1:0); bit0 ignored.
- fml_stb_i  in  1  request strobe.
- fml_we_i  in  1  1=write.
- fml_sel_i  in  2  byte enables within the half.
- fml_di_i  in  16  write data.
- fml_do_o  out  16  read data; valid in the fml_ack_o cycle.
- fml_ack_o  out  1  one-cycle completion pulse.
- wb_adr_o  out  32  {zero-pad, fml_adr_i[ADR_W-1:2], 2'b00}.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte enables.
- wb_cti_o  out  3  constant 3'b000 (classic cycle).
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe; equal to wb_cyc_o.
- wb_we_o  out  1  write enable.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pend_v=0, cache_v=0. Reset during an active WB cycle abandons it; no ack is issued afterwards.
- Outputs: all are registered.
- FSM states: IDLE, FLUSH, WB_WR, WB_RD, ACK.
- Request sampling: IDLE samples a request only when fml_stb_i=1 and fml_ack_o=0. The master holds stb high across back-to-back requests, so the cycle after an ack can hold a new request.
- Word match: wmatch = (fml_adr_i[ADR_W-1:2] equals the stored word address).
- Write, upper half: latch hi_dat, hi_sel, and the word address. Set pend_v.
  - If pend_v was already set, the old buffer is overwritten; no WB cycle.
  - Go to ACK, so latency is 1 cycle.
  - If cache_v and wmatch, clear cache_v.
- Write, lower half, pend_v=1 and wmatch: WB_WR with dat={hi_dat,fml_di_i}, sel={hi_sel,fml_sel_i}. Clear pend_v.
- Write, lower half, pend_v=0: WB_WR with dat={16'h0,fml_di_i}, sel={2'b00,fml_sel_i}.
- Write, lower half, pend_v=1 and no wmatch: first FLUSH, a WB write of {hi_dat,16'h0} with sel {hi_sel,2'b00} to the stored address. Then the WB_WR above.
- Any lower write: if cache_v and wmatch, clear cache_v.
- Read with pend_v=1: FLUSH first, whatever the address.
- Read, cache_v and wmatch: go to ACK and return the cached half (cache[31:16] or cache[15:0]). Latency 1 cycle.
- Read, otherwise: WB_RD. On wb_ack_i, capture wb_dat_i into the cache, store the word address, set cache_v, and return the selected half.
- WB handshake: cyc=stb=1 held with stable adr/dat/sel/we until wb_ack_i. Deassert in the cycle after ack.
  - FLUSH then returns to dispatch: WB_WR or WB_RD, or ACK on a cache hit.
  - WB_WR and WB_RD go to ACK.
- ACK: fml_ack_o=1 for exactly one cycle, then IDLE.
  - fml_do_o is updated in the cycle ack rises and holds until the next read ack.
  - fml_do_o is unchanged for writes.
- Timing: WB latency L cycles from stb gives FML latency L+1. FLUSH adds L+1.
- fml_stb_i dropping mid-operation: the operation completes and acks anyway, since the master never aborts.
- Cache coherency: writes never update the cache; only invalidation keeps it coherent.

Decomposition:
- Shared package `fml16_pkg`:
  - FSM state encoding (3 bits).
  - Half-select constants HALF_UPPER=0, HALF_LOWER=1.
  - WB CTI classic constant.
- Sub-module `fml16_wb32_wbm`: single-cycle Wishbone master issuing one classic cycle (start, we, adr, dat, sel -> done, rdata).
- Top level holds the FSM, the write-pending buffer, and the read cache.

Test Plan:
- Write pair: write upper 16'hDEAD (adr 0x100), then lower 16'hBEEF (adr 0x102), sel 2'b11 -> exactly one WB write, adr 0x100, dat 32'hDEADBEEF, sel 4'hF. First FML ack 1 cycle after stb; second ack 1 cycle after wb_ack_i.
- Read pair: wb slave returns 32'h12345678 at 0x200; read upper then lower -> fml_do_o 16'h1234, then 16'h5678; one WB read only; second ack 1 cycle after stb.
- Orphan upper write: upper write 16'hAAAA at 0x300, then read 0x400 -> WB write {16'hAAAA,16'h0} sel 4'hC to 0x300 first, then WB read 0x400.
- Lone lower write: lower write 16'h5555 at 0x306 with pend_v=0 -> WB write adr 0x304, sel 4'h3, dat 32'h00005555.
- Cache invalidation: cache 0x200 by a read, write a pair to 0x200, read upper at 0x200 -> a new WB read is issued; no stale data.
- Reset mid-cycle: assert sys_rst_n=0 with wb_cyc_o=1 and no wb_ack_i -> wb_cyc_o=0 and fml_ack_o=0 immediately. After release, a cache-hit candidate read issues a WB read because the cache is invalid.
